// File: rtl/vga_timing_640_480.sv
// Raster timing generator for 640x480 @ 60 Hz VGA: h/v position counters advanced
// by a pixel-clock enable, with sync / visible-area decodes and pixel coordinates.
module vga_timing_640_480 #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic       o_hsync_en,
  output logic       o_vsync_en,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_line_end,
  output logic       o_frame_end
);

  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_WRAP       = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_WRAP       = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;
  logic       h_at_wrap, v_at_wrap;

  assign h_at_wrap = (h_reg == H_WRAP);
  assign v_at_wrap = (v_reg == V_WRAP);

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (i_px_clk) begin
      if (h_at_wrap) begin
        h_next = '0;
        v_next = v_at_wrap ? 10'd0 : v_reg + 10'd1;
      end else begin
        h_next = h_reg + 10'd1;
      end
    end
  end

  // Clear wins over a coincident strobe: a mid-frame clear lands exactly on (0,0).
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      h_reg <= '0;
      v_reg <= '0;
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
    end
  end

  assign o_haddr_en = (h_reg < H_VIS_END);
  assign o_vaddr_en = (v_reg < V_VIS_END);
  assign o_hsync_en = (h_reg >= H_SYNC_START) && (h_reg < H_SYNC_END);
  assign o_vsync_en = (v_reg >= V_SYNC_START) && (v_reg < V_SYNC_END);
  assign o_vga_hs   = ~o_hsync_en;
  assign o_vga_vs   = ~o_vsync_en;

  assign o_line_end  = i_px_clk & h_at_wrap;
  assign o_frame_end = i_px_clk & h_at_wrap & v_at_wrap;

  // Coordinates are forced to zero outside the visible area.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_hidx
      assign o_hidx[gi] = h_reg[gi] & o_haddr_en;
    end
    for (gi = 0; gi < 9; gi++) begin : g_vidx
      assign o_vidx[gi] = v_reg[gi] & o_vaddr_en;
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Directed bench: default-mode horizontal sweep, strobe gating and clear, plus a
// reduced-parameter instance small enough to cover whole frames.
module tb_vga_timing_640_480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // default-mode instance
  logic       d_sclr = 1'b0, d_px = 1'b0;
  logic [9:0] d_hidx;
  logic [8:0] d_vidx;
  logic       d_haddr, d_vaddr, d_hsync, d_vsync, d_hs, d_vs, d_line, d_frame;

  vga_timing_640_480 u_dut (
    .clk(clk), .i_sclr(d_sclr), .i_px_clk(d_px),
    .o_hidx(d_hidx), .o_vidx(d_vidx),
    .o_haddr_en(d_haddr), .o_vaddr_en(d_vaddr),
    .o_hsync_en(d_hsync), .o_vsync_en(d_vsync),
    .o_vga_hs(d_hs), .o_vga_vs(d_vs),
    .o_line_end(d_line), .o_frame_end(d_frame)
  );

  // reduced instance: line total 12, frame total 7 lines
  logic       r_sclr = 1'b0, r_px = 1'b0;
  logic [9:0] r_hidx;
  logic [8:0] r_vidx;
  logic       r_haddr, r_vaddr, r_hsync, r_vsync, r_hs, r_vs, r_line, r_frame;

  vga_timing_640_480 #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_small (
    .clk(clk), .i_sclr(r_sclr), .i_px_clk(r_px),
    .o_hidx(r_hidx), .o_vidx(r_vidx),
    .o_haddr_en(r_haddr), .o_vaddr_en(r_vaddr),
    .o_hsync_en(r_hsync), .o_vsync_en(r_vsync),
    .o_vga_hs(r_hs), .o_vga_vs(r_vs),
    .o_line_end(r_line), .o_frame_end(r_frame)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hsync_cnt, hsync_first, haddr_cnt, line_cnt, line_at, hidx_bad;
    int vsync_cnt, vsync_first, vaddr_cnt, hs_cnt, frame_cnt, frame_at;
    int hold_hidx;

    // ---- reset from arbitrary counters ----
    d_px = 1'b1; r_px = 1'b1;
    repeat (37) tick();
    d_sclr = 1'b1; d_px = 1'b0; r_sclr = 1'b1; r_px = 1'b0;
    tick();
    d_sclr = 1'b0; r_sclr = 1'b0;
    check_eq("rst_hidx",  d_hidx,  0);
    check_eq("rst_vidx",  d_vidx,  0);
    check_eq("rst_haddr", d_haddr, 1);
    check_eq("rst_vaddr", d_vaddr, 1);
    check_eq("rst_hsync", d_hsync, 0);
    check_eq("rst_vsync", d_vsync, 0);
    check_eq("rst_vga_hs", d_hs, 1);
    check_eq("rst_vga_vs", d_vs, 1);
    check_eq("rst_line_end", d_line, 0);
    check_eq("rst_frame_end", d_frame, 0);

    // ---- horizontal sweep, strobe every clk ----
    d_px = 1'b1;
    hsync_cnt = 0; hsync_first = -1; haddr_cnt = 0; line_cnt = 0; line_at = -1; hidx_bad = 0;
    for (int k = 0; k < 800; k++) begin
      if (d_hsync) begin
        hsync_cnt++;
        if (hsync_first < 0) hsync_first = k;
      end
      if (d_haddr) haddr_cnt++;
      if (d_line) begin line_cnt++; line_at = k; end
      if (k >= 640 && d_hidx != 0) hidx_bad++;
      if (k < 640 && d_hidx != k) hidx_bad++;
      tick();
    end
    check_eq("sweep_haddr_ticks", haddr_cnt, 640);
    check_eq("sweep_hsync_ticks", hsync_cnt, 96);
    check_eq("sweep_hsync_start", hsync_first, 656);
    check_eq("sweep_line_pulses", line_cnt, 1);
    check_eq("sweep_line_at", line_at, 799);
    check_eq("sweep_hidx_bad", hidx_bad, 0);
    check_eq("wrap_hidx", d_hidx, 0);
    check_eq("wrap_vidx", d_vidx, 1);

    // ---- strobe gating: one strobe every 4 clk ----
    line_cnt = 0; line_at = -1; hold_hidx = -1;
    for (int c = 0; c < 3200; c++) begin
      d_px = (c % 4 == 0);
      #0;
      if (d_line) begin line_cnt++; line_at = c; end
      tick();
      if (c == 3) hold_hidx = d_hidx;
    end
    d_px = 1'b0;
    check_eq("gate_hold_hidx", hold_hidx, 1);
    check_eq("gate_line_pulses", line_cnt, 1);
    check_eq("gate_line_at_clk", line_at, 3196);
    check_eq("gate_end_hidx", d_hidx, 0);
    check_eq("gate_end_vidx", d_vidx, 2);

    // ---- mid-line clear with coincident strobe, default mode at (700,2) ----
    d_px = 1'b1;
    repeat (700) tick();
    check_eq("pre_clr_hsync", d_hsync, 1);
    check_eq("pre_clr_haddr", d_haddr, 0);
    d_sclr = 1'b1;
    tick();
    d_sclr = 1'b0; d_px = 1'b0;
    check_eq("clr_hidx", d_hidx, 0);
    check_eq("clr_vidx", d_vidx, 0);
    check_eq("clr_haddr", d_haddr, 1);
    check_eq("clr_hsync", d_hsync, 0);

    // ---- reduced parameters: whole frame of 84 strobes ----
    r_px = 1'b1;
    vsync_cnt = 0; vsync_first = -1; vaddr_cnt = 0; haddr_cnt = 0; hs_cnt = 0;
    line_cnt = 0; frame_cnt = 0; frame_at = -1;
    for (int k = 0; k < 84; k++) begin
      if (r_vsync) begin
        vsync_cnt++;
        if (vsync_first < 0) vsync_first = k;
      end
      if (r_vaddr) vaddr_cnt++;
      if (r_haddr) haddr_cnt++;
      if (r_hsync) hs_cnt++;
      if (r_line) line_cnt++;
      if (r_frame) begin frame_cnt++; frame_at = k; end
      tick();
    end
    check_eq("small_vsync_ticks", vsync_cnt, 12);
    check_eq("small_vsync_start", vsync_first, 60);
    check_eq("small_vaddr_ticks", vaddr_cnt, 48);
    check_eq("small_haddr_ticks", haddr_cnt, 56);
    check_eq("small_hsync_ticks", hs_cnt, 14);
    check_eq("small_line_pulses", line_cnt, 7);
    check_eq("small_frame_pulses", frame_cnt, 1);
    check_eq("small_frame_at", frame_at, 83);
    check_eq("small_wrap_hidx", r_hidx, 0);
    check_eq("small_wrap_vidx", r_vidx, 0);
    check_eq("small_wrap_vs", r_vs, 1);

    // ---- reduced: run to (4,3), then clear with coincident strobe ----
    repeat (40) tick();
    check_eq("small_pre_hidx", r_hidx, 4);
    check_eq("small_pre_vidx", r_vidx, 3);
    r_sclr = 1'b1;
    tick();
    r_sclr = 1'b0; r_px = 1'b0;
    check_eq("small_clr_hidx", r_hidx, 0);
    check_eq("small_clr_vidx", r_vidx, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
